// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ID-stage register file with write-back scoreboard.
//   NUM_RD combinational read ports with write-through bypass, one WB write
//   port, and a per-register pending-write counter for RAW stall detection.
//   Address 15 always reads pc_in.
// Ports:
//   clk, rst (async, active low)
//   pc_in                        value returned for address 15
//   rd_addr / rd_data / rd_busy  flattened read ports, port k at [k*W +: W]
//   wb_en, wb_dest, wb_value     write-back port (also retires one pending write)
//   issue_en, issue_dest         ID issue of a writing instruction (pending +1)
//   issue_full                   issue_dest already has MAX_INFLIGHT pending
//   sb_err                       sticky: WB with nothing pending, or issue while full
// Optional: define REGFILE_STATUS_EN to add the NZCV status register
//   (status_we, status_in, status_out).

module regfile_rd_port #(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 15,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 2
) (
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [WORD_LEN-1:0]                  pc_in,
  input  logic [WORD_COUNT-1:0][WORD_LEN-1:0]  regs,
  input  logic [WORD_COUNT-1:0][CNT_W-1:0]     cnt,
  input  logic                                 wb_valid,
  input  logic [ADDR_W-1:0]                    wb_dest,
  input  logic [WORD_LEN-1:0]                  wb_value,
  output logic [WORD_LEN-1:0]                  data,
  output logic                                 busy
);
  localparam logic [ADDR_W:0] PC_A = (ADDR_W+1)'(15);
  localparam logic [ADDR_W:0] WC   = (ADDR_W+1)'(WORD_COUNT);

  logic hit;
  assign hit = wb_valid && (wb_dest == addr);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if ({1'b0, addr} == PC_A) begin
      data = pc_in;
    end else if ({1'b0, addr} < WC) begin
      data = hit ? wb_value : regs[addr];
      // the last outstanding write landing this cycle is served by the bypass
      busy = (cnt[addr] > CNT_W'(1)) || ((cnt[addr] == CNT_W'(1)) && !hit);
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int WORD_LEN     = 32,
  parameter int WORD_COUNT   = 15,
  parameter int NUM_RD       = 3,
  parameter int MAX_INFLIGHT = 3,
  parameter int ADDR_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_LEN-1:0]        pc_in,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*WORD_LEN-1:0] rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_dest,
  input  logic [WORD_LEN-1:0]        wb_value,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_dest,
  output logic                       issue_full,
  output logic                       sb_err
`ifdef REGFILE_STATUS_EN
  ,
  input  logic                       status_we,
  input  logic [3:0]                 status_in,
  output logic [3:0]                 status_out
`endif
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ADDR_W:0]  PC_A    = (ADDR_W+1)'(15);
  localparam logic [ADDR_W:0]  WC      = (ADDR_W+1)'(WORD_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [WORD_COUNT-1:0][WORD_LEN-1:0] regs;
  logic [WORD_COUNT-1:0][CNT_W-1:0]    cnt;
  logic [WORD_COUNT-1:0]               inc, dec;
  logic                                wb_valid, issue_ok, err_set;

  // PC address and anything past the physical file are not real registers
  assign wb_valid = wb_en && ({1'b0, wb_dest} != PC_A) && ({1'b0, wb_dest} < WC);
  assign issue_ok = ({1'b0, issue_dest} != PC_A) && ({1'b0, issue_dest} < WC);

  // a retiring write to the same register frees a slot this cycle
  assign issue_full = issue_ok && (cnt[issue_dest] == CNT_MAX) &&
                      !(wb_valid && (wb_dest == issue_dest));

  always_comb begin
    inc     = '0;
    dec     = '0;
    err_set = issue_en && issue_full;
    for (int i = 0; i < WORD_COUNT; i++) begin
      inc[i] = issue_en && issue_ok && !issue_full && (issue_dest == ADDR_W'(i));
      dec[i] = wb_valid && (wb_dest == ADDR_W'(i));
      if (dec[i] && !inc[i] && (cnt[i] == '0)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        regs[i] <= WORD_LEN'(i);
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_valid) regs[wb_dest] <= wb_value;
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (inc[i] && !dec[i])                     cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (err_set) sb_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .WORD_LEN(WORD_LEN), .WORD_COUNT(WORD_COUNT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_rd (
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .pc_in    (pc_in),
      .regs     (regs),
      .cnt      (cnt),
      .wb_valid (wb_valid),
      .wb_dest  (wb_dest),
      .wb_value (wb_value),
      .data     (rd_data[k*WORD_LEN +: WORD_LEN]),
      .busy     (rd_busy[k])
    );
  end

`ifdef REGFILE_STATUS_EN
  logic [3:0] status_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           status_q <= 4'b0;
    else if (status_we) status_q <= status_in;
  end
  assign status_out = status_we ? status_in : status_q;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int WL = 32, WC = 15, NR = 3, MAXF = 3, AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [WL-1:0]     pc_in;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*WL-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wb_en;
  logic [AW-1:0]     wb_dest;
  logic [WL-1:0]     wb_value;
  logic              issue_en;
  logic [AW-1:0]     issue_dest;
  logic              issue_full;
  logic              sb_err;
`ifdef REGFILE_STATUS_EN
  logic              status_we;
  logic [3:0]        status_in;
  logic [3:0]        status_out;
`endif

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .issue_en(issue_en), .issue_dest(issue_dest), .issue_full(issue_full),
    .sb_err(sb_err)
`ifdef REGFILE_STATUS_EN
    , .status_we(status_we), .status_in(status_in), .status_out(status_out)
`endif
  );

  always #5 clk = ~clk;

  // reference model: architectural register values, pending-write counts, error flag
  int unsigned m_reg [WC];
  int          m_cnt [WC];
  bit          m_err;
  int          vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < WC; i++) begin m_reg[i] = i; m_cnt[i] = 0; end
    m_err = 0;
  endtask

  function automatic bit real_reg(input int a);
    return a < WC;
  endfunction

  function automatic bit exp_full();
    return real_reg(int'(issue_dest)) && m_cnt[issue_dest] == MAXF &&
           !(wb_en && wb_dest == issue_dest);
  endfunction

  task automatic check_model();
    for (int k = 0; k < NR; k++) begin
      int a;
      logic [31:0] ed;
      bit eb;
      a = int'(rd_addr[k*AW +: AW]);
      eb = 0;
      if (a == 15) ed = pc_in;
      else if (!real_reg(a)) ed = 0;
      else begin
        ed = (wb_en && int'(wb_dest) == a) ? wb_value : m_reg[a];
        eb = m_cnt[a] > 1 || (m_cnt[a] == 1 && !(wb_en && int'(wb_dest) == a));
      end
      chk($sformatf("rd_data%0d", k), rd_data[k*WL +: WL], ed);
      chk($sformatf("rd_busy%0d", k), {31'b0, rd_busy[k]}, {31'b0, eb});
    end
    chk("issue_full", {31'b0, issue_full}, {31'b0, exp_full()});
    chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
  endtask

  task automatic model_step();
    bit full, inc, dec;
    full = exp_full();
    inc  = issue_en && real_reg(int'(issue_dest)) && !full;
    dec  = wb_en && real_reg(int'(wb_dest));
    if (issue_en && full) m_err = 1;
    if (dec) m_reg[wb_dest] = wb_value;
    if (inc && dec && issue_dest == wb_dest) begin
      // net zero, no error
    end else begin
      if (inc) m_cnt[issue_dest]++;
      if (dec) begin
        if (m_cnt[wb_dest] > 0) m_cnt[wb_dest]--;
        else m_err = 1;
      end
    end
  endtask

  task automatic look();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    look(); adv();
  endtask

  task automatic idle();
    wb_en = 0; issue_en = 0;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    check_model();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; pc_in = 32'h40; rd_addr = '0; wb_dest = '0; wb_value = '0;
    issue_dest = '0; idle();
`ifdef REGFILE_STATUS_EN
    status_we = 0; status_in = 4'b0;
`endif
    model_reset();
    #12;
    // reset state and plain reads
    set_rd(4'd2, 4'd7, 4'd15);
    do_reset();
    look();
    chk("rst_r2", rd_data[31:0], 32'd2);
    chk("rst_r7", rd_data[63:32], 32'd7);
    chk("rst_pc", rd_data[95:64], 32'h40);
    chk("rst_busy", {29'b0, rd_busy}, 32'd0);
    adv();

    // single pending write, unblocked by bypass on arrival
    set_rd(4'd3, 4'd3, 4'd3);
    issue_en = 1; issue_dest = 3; tick(); idle();
    repeat (3) begin
      look(); chk("r3_busy", {31'b0, rd_busy[0]}, 32'd1); adv();
    end
    wb_en = 1; wb_dest = 3; wb_value = 32'hABCD;
    look();
    chk("r3_bypass", rd_data[31:0], 32'hABCD);
    chk("r3_unbusy", {31'b0, rd_busy[0]}, 32'd0);
    adv(); idle();
    look(); chk("r3_after", {31'b0, rd_busy[0]}, 32'd0); adv();

    // simultaneous issue and wb to R4
    set_rd(4'd4, 4'd4, 4'd4);
    issue_en = 1; issue_dest = 4; tick();
    wb_en = 1; wb_dest = 4; wb_value = 32'h44; tick(); idle();
    look(); chk("r4_still_busy", {31'b0, rd_busy[0]}, 32'd1); adv();
    wb_en = 1; wb_dest = 4; wb_value = 32'h45; tick(); idle();
    look(); chk("r4_free", {31'b0, rd_busy[0]}, 32'd0); adv();

    // unmatched WB sets sb_err; reset clears it and restores R9
    set_rd(4'd9, 4'd9, 4'd9);
    wb_en = 1; wb_dest = 9; wb_value = 32'h99; tick(); idle();
    look(); chk("r9_written", rd_data[31:0], 32'h99); chk("err_wb", {31'b0, sb_err}, 32'd1); adv();
    do_reset();
    look(); chk("err_cleared", {31'b0, sb_err}, 32'd0); chk("r9_reset", rd_data[31:0], 32'd9); adv();

    // fill R5 to the limit, violate, then relieve with a WB
    set_rd(4'd5, 4'd0, 4'd15);
    issue_dest = 5;
    repeat (3) begin issue_en = 1; tick(); end
    idle();
    look(); chk("r5_full", {31'b0, issue_full}, 32'd1); adv();
    issue_en = 1; tick(); idle();
    look(); chk("r5_violation_err", {31'b0, sb_err}, 32'd1);
    chk("r5_still_full", {31'b0, issue_full}, 32'd1); adv();
    wb_en = 1; wb_dest = 5; wb_value = 32'h55;
    look(); chk("r5_full_drop", {31'b0, issue_full}, 32'd0); adv();
    idle();

`ifdef REGFILE_STATUS_EN
    status_we = 1; status_in = 4'b1010;
    look(); chk("status_bypass", {28'b0, status_out}, 32'hA); adv();
    status_we = 0; status_in = 4'b0101;
    look(); chk("status_hold", {28'b0, status_out}, 32'hA); adv();
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      pc_in    = $urandom;
      rd_addr  = NR*AW'($urandom);
      issue_en = ($urandom_range(0, 1) == 1);
      issue_dest = AW'($urandom_range(0, 15));
      wb_en    = ($urandom_range(0, 2) != 0);
      r        = $urandom_range(0, 14);
      // mostly retire a register that actually has something pending
      wb_dest  = (m_cnt[r] > 0 || $urandom_range(0, 7) == 0) ? AW'(r) : AW'($urandom_range(0, 15));
      wb_value = $urandom;
      if (n % 8 == 0) rd_addr[AW-1:0] = issue_dest;
      if (n % 5 == 0) rd_addr[2*AW-1:AW] = wb_dest;
      tick();
      if (n == 200) do_reset();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
